tdc_phase_encoder: RTL

- Inverse of the TDC digital decoder: turns an accumulated phase word into the raw TDC front-end pattern.
  - 7-bit coarse counter.
  - 16-bit cyclic thermometer phase word.
- Used as a synthesizable stimulus/emulation source that drives the decoder's counter_in/phase_in in ADPLL loop testbenches and FPGA emulation.
- A fractional phase accumulator advances by a frequency control word each enabled cycle. The integer part is encoded with the same edge-index and retiming conventions the decoder inverts.

---
 rtl/tdc_phase_encoder.sv | 91 +++++++++
 1 files changed

// File: rtl/tdc_phase_encoder.sv
// tdc_phase_encoder: turns a fractional phase accumulator into the raw TDC
// front-end pattern, a 7-bit coarse counter plus a 16-bit cyclic thermometer
// word. It is the exact inverse of the TDC decoder and serves as a
// synthesizable stimulus source for ADPLL benches and FPGA emulation.
module tdc_phase_encoder #(
  parameter int          FRAC_W    = 4,
  parameter logic [11:0] RST_PHASE = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [12+FRAC_W-1:0] fcw,
  input  logic                load,
  input  logic [11:0]         load_val,
  output logic [6:0]          counter_out,
  output logic [15:0]         phase_out,
  output logic                valid_out
);

  localparam int ACC_W = 12 + FRAC_W;

  // Cyclic thermometer code of a 5-bit edge index.
  // e = 0..15 : ones fill upward from bit 0 (bits 0..e set).
  // e = 16..31: zeros fill upward from bit 0 (bits 0..e-16 clear).
  // A 17-bit shift handles e = 31 without a 4-bit shift-amount overflow.
  function automatic logic [15:0] therm_f(input logic [4:0] e);
    logic [16:0] shifted;
    logic [15:0] result;
    shifted = 17'h1FFFF << ({1'b0, e[3:0]} + 5'd1);
    if (e[4] == 1'b0) begin
      result = ~(16'hFFFE << e[3:0]);
    end else begin
      result = shifted[15:0];
    end
    return result;
  endfunction

  logic [ACC_W-1:0] acc_q,       acc_d;
  logic             acc_vld_q,   acc_vld_d;
  logic [6:0]       counter_q,   counter_d;
  logic [15:0]      phase_q,     phase_d;
  logic             valid_q;

  logic [11:0]      int_phase_s;

  // Accumulator next state: load has priority over en, wrap is silent.
  always_comb begin
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    if (load) begin
      acc_d     = {load_val, {FRAC_W{1'b0}}};
      acc_vld_d = 1'b1;
    end else if (en) begin
      acc_d     = acc_q + fcw;
      acc_vld_d = 1'b1;
    end else begin
      acc_d     = acc_q;
      acc_vld_d = acc_vld_q;
    end
  end

  // Encoder next state; the counter is pre-incremented whenever phase bit 0
  // is set, matching the decoder's retiming subtraction.
  always_comb begin
    int_phase_s = acc_q[ACC_W-1:FRAC_W];
    phase_d     = therm_f(int_phase_s[4:0]);
    counter_d   = int_phase_s[11:5] + {6'd0, phase_d[0]};
  end

  // Stage 1 accumulator and stage 2 output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= {RST_PHASE, {FRAC_W{1'b0}}};
      acc_vld_q <= 1'b0;
      counter_q <= 7'd0;
      phase_q   <= 16'h0000;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      counter_q <= counter_d;
      phase_q   <= phase_d;
      valid_q   <= acc_vld_q;
    end
  end

  assign counter_out = counter_q;
  assign phase_out   = phase_q;
  assign valid_out   = valid_q;

endmodule
